cpu_bus_sync: RTL and testbench
===============================

Name: cpu_bus_sync

Overview:
- Upstream front-end for the mapper layer: samples the asynchronous 68k cartridge bus into the FPGA clock domain.
- Per-strobe path: metastability synchroniser, then a deglitch filter.
- Outputs: clean registered strobes, held address/data, and single-cycle read/write event pulses.
- Consumers: the mapper and backup-RAM write logic (SRAM/EEPROM save stages) take its registered bus and use the pulses instead of raw level strobes.

Parameters:
SYNC_STAGES, 2, synchroniser flops per strobe (legal 2..3)
FILT_LEN, 2, consecutive identical synced samples required before a filtered strobe changes (legal 1..4)
TIMEOUT, 255, max cycles filtered as_n may stay low before bus_err (8-bit counter)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bus_addr  in  24  raw 68k address
bus_data  in  16  raw 68k write data
bus_as_n  in  1  raw address strobe
bus_oe_n  in  1  raw output enable
bus_ce_lo_n  in  1  raw /CE lower ROM space
bus_ce_hi_n  in  1  raw /CE upper space
bus_we_lo_n  in  1  raw lower-byte write strobe
bus_we_hi_n  in  1  raw upper-byte write strobe
addr_q  out  24  held address
data_q  out  16  held write data
as_q, oe_q, ce_lo_q, ce_hi_q, we_lo_q, we_hi_q  out  1 each  filtered strobes, active-low
rd_stb  out  1  one-cycle pulse on filtered oe_n fall
wr_stb_lo, wr_stb_hi  out  1 each  one-cycle pulse on filtered we fall
bus_err  out  1  access exceeded TIMEOUT
proto_err  out  1  one-cycle pulse: oe and we both asserted

Behaviour:
- Reset (async, rst_n low):
  - All sync and filter flops set to 1; all *_q strobes = 1.
  - addr_q = 0, data_q = 0; all pulses = 0; bus_err = 0; FSM = IDLE; counter = 0.
- Release is synchronous in effect: the first filtered transition needs a full SYNC_STAGES+FILT_LEN cycles of valid input after reset deasserts.
- Strobe path, per strobe:
  - Synchroniser of SYNC_STAGES flops.
  - Filter changes its output only after FILT_LEN consecutive equal synced samples that differ from the current output.
  - A shorter glitch is invisible.
  - Latency from a raw edge to the filtered edge = SYNC_STAGES + FILT_LEN cycles.
- Address/data path:
  - Raw addr/data go through a plain delay pipe of depth SYNC_STAGES + FILT_LEN, so they are aligned with the filtered strobes.
  - addr_q loads from the pipe every cycle while as_q = 1; it freezes from the cycle as_q falls until as_q rises.
  - data_q loads every cycle while we_lo_q & we_hi_q = 1; it freezes while either is low.
- Pulses:
  - Each pulse asserts in the cycle the filtered strobe goes 1->0, and lasts exactly one cycle.
  - No repeat until the strobe has risen again.
  - wr_stb_lo and wr_stb_hi may fire in the same cycle (word write).
  - Same-cycle oe/we fall: write pulses fire, rd_stb is suppressed, proto_err pulses.
  - oe falling while a we is already low: rd_stb suppressed, proto_err pulses.
- FSM, transitions evaluated on filtered signals:
  - IDLE -> ACTIVE on as_q fall. Counter cleared.
  - ACTIVE -> READ on oe fall; ACTIVE -> WRITE on either we fall.
  - READ / WRITE / ACTIVE: counter increments each cycle while as_q = 0. Counter reaching TIMEOUT -> TOUT with bus_err = 1.
  - Any state -> IDLE on as_q rise; this clears bus_err and the counter.
  - TOUT holds bus_err high until as_q rises.
  - Counter saturates at 255.
- Pulses are independent of the FSM: ce-only accesses without as still generate rd_stb/wr_stb.
- FSM is for the timeout only.

Decomposition:
- Shared package (map_pkg): FSM state enum (IDLE, ACTIVE, READ, WRITE, TOUT) and the default parameter constants.
- One sub-module, sync_filt: 1-bit synchroniser + deglitch filter + falling-edge pulse; instantiated six times.

Test Plan:
- Reset check: hold rst_n low mid-access -> all *_q = 1, pulses 0, addr_q = 0; after release, bus idle 10 cycles -> no pulses.
- Read cycle: addr 0x200000, as_n low, then oe_n low 3 cycles later, held 10 cycles -> rd_stb exactly once, 4 cycles after raw oe fall (defaults); addr_q = 0x200000 held until as_q rises.
- Word write:
  - Stimulus: data 0xA55A, we_lo_n/we_hi_n low together for 8 cycles.
  - Response: wr_stb_lo and wr_stb_hi pulse in the same cycle; data_q = 0xA55A during the pulse; data_q unchanged when bus data changes while we is low.
- Glitch rejection: 1-cycle low pulse on bus_we_lo_n (FILT_LEN = 2) -> no wr_stb_lo, we_lo_q stays 1.
- Timeout: as_n held low 300 cycles -> bus_err rises 255 cycles after as_q fall; clears the cycle after as_q rises.
- Conflict: oe_n and we_hi_n fall in the same cycle -> wr_stb_hi = 1, rd_stb = 0, proto_err one-cycle pulse.

Source files
------------

// File: rtl/map_pkg.sv
// ============================================================================
// Module : map_pkg
// Brief  : Shared FSM state encoding, strobe indices and default parameters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package map_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        READ   = 3'd2,
        WRITE  = 3'd3,
        TOUT   = 3'd4
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_FILT_LEN    = 2;
    localparam int unsigned DEF_TIMEOUT     = 255;

    // Bit positions of the six bus strobes inside the packed strobe vector
    localparam int unsigned IDX_AS      = 0;
    localparam int unsigned IDX_OE      = 1;
    localparam int unsigned IDX_CE_LO   = 2;
    localparam int unsigned IDX_CE_HI   = 3;
    localparam int unsigned IDX_WE_LO   = 4;
    localparam int unsigned IDX_WE_HI   = 5;
    localparam int unsigned NUM_STROBES = 6;

endpackage

`default_nettype wire

// File: rtl/sync_filt.sv
// ============================================================================
// Module : sync_filt
// Brief  : 1-bit synchroniser, deglitch filter and falling-edge pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_q,
    output logic o_fall
);

    localparam logic [1:0] c_cnt_last = 2'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_cnt;
    logic                   r_q;
    logic                   r_fall;
    logic                   w_sync;
    logic                   w_diff;
    logic                   w_flip;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_diff = (w_sync != r_q);
    // r_cnt holds how many differing samples preceded this one
    assign w_flip = w_diff && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_q    <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_fall <= w_flip && !w_sync;
            if (w_flip) begin
                r_q   <= w_sync;
                r_cnt <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 2'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_q    = r_q;
    assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/cpu_bus_sync.sv
// ============================================================================
// Module : cpu_bus_sync
// Brief  : Samples the async 68k cartridge bus into clk, with event pulses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_sync
    import map_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bus_addr,
    input  logic [15:0] bus_data,
    input  logic        bus_as_n,
    input  logic        bus_oe_n,
    input  logic        bus_ce_lo_n,
    input  logic        bus_ce_hi_n,
    input  logic        bus_we_lo_n,
    input  logic        bus_we_hi_n,
    output logic [23:0] addr_q,
    output logic [15:0] data_q,
    output logic        as_q,
    output logic        oe_q,
    output logic        ce_lo_q,
    output logic        ce_hi_q,
    output logic        we_lo_q,
    output logic        we_hi_q,
    output logic        rd_stb,
    output logic        wr_stb_lo,
    output logic        wr_stb_hi,
    output logic        bus_err,
    output logic        proto_err
);

    // addr_q/data_q form the final stage, so the pipe itself is one shorter
    localparam int         c_PIPE    = SYNC_STAGES + FILT_LEN - 1;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [NUM_STROBES-1:0] w_raw;
    logic [NUM_STROBES-1:0] w_q;
    logic [NUM_STROBES-1:0] w_fall;
    logic                   w_we_idle;
    logic                   w_we_fall;
    logic                   w_unused;

    logic [23:0] r_addr_pipe [c_PIPE];
    logic [15:0] r_data_pipe [c_PIPE];
    logic [23:0] r_addr_q;
    logic [15:0] r_data_q;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;

    assign w_raw = {bus_we_hi_n, bus_we_lo_n, bus_ce_hi_n,
                    bus_ce_lo_n, bus_oe_n, bus_as_n};

    for (genvar gi = 0; gi < NUM_STROBES; gi++) begin : g_strobe
        sync_filt #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_sync_filt (
            .clk   (clk),
            .rst_n (rst_n),
            .i_raw (w_raw[gi]),
            .o_q   (w_q[gi]),
            .o_fall(w_fall[gi])
        );
    end

    assign w_unused  = &{1'b0, w_fall[IDX_CE_LO], w_fall[IDX_CE_HI]};
    assign w_we_idle = w_q[IDX_WE_LO] & w_q[IDX_WE_HI];
    assign w_we_fall = w_fall[IDX_WE_LO] | w_fall[IDX_WE_HI];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_PIPE; i++) begin
                r_addr_pipe[i] <= '0;
                r_data_pipe[i] <= '0;
            end
            r_addr_q <= '0;
            r_data_q <= '0;
        end else begin
            r_addr_pipe[0] <= bus_addr;
            r_data_pipe[0] <= bus_data;
            for (int i = 1; i < c_PIPE; i++) begin
                r_addr_pipe[i] <= r_addr_pipe[i-1];
                r_data_pipe[i] <= r_data_pipe[i-1];
            end
            if (w_q[IDX_AS]) begin
                r_addr_q <= r_addr_pipe[c_PIPE-1];
            end
            if (w_we_idle) begin
                r_data_q <= r_data_pipe[c_PIPE-1];
            end
        end
    end

    // Counter value = number of cycles filtered as_n has been seen low
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_q[IDX_AS]) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall[IDX_AS]) begin
                        w_cnt_nxt = 8'd1;
                        if (w_fall[IDX_OE])  w_state_nxt = READ;
                        else if (w_we_fall)  w_state_nxt = WRITE;
                        else                 w_state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_fall[IDX_OE])  w_state_nxt = READ;
                    else if (w_we_fall)  w_state_nxt = WRITE;
                end
                READ, WRITE, TOUT: w_cnt_nxt = w_cnt_inc;
                default: w_state_nxt = IDLE;
            endcase
            if ((w_state_nxt != IDLE) && (w_cnt_nxt >= c_TIMEOUT)) begin
                w_state_nxt = TOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign addr_q    = r_addr_q;
    assign data_q    = r_data_q;
    assign as_q      = w_q[IDX_AS];
    assign oe_q      = w_q[IDX_OE];
    assign ce_lo_q   = w_q[IDX_CE_LO];
    assign ce_hi_q   = w_q[IDX_CE_HI];
    assign we_lo_q   = w_q[IDX_WE_LO];
    assign we_hi_q   = w_q[IDX_WE_HI];
    // A read that starts while a write strobe is low is a protocol conflict
    assign rd_stb    = w_fall[IDX_OE] & w_we_idle;
    assign proto_err = w_fall[IDX_OE] & ~w_we_idle;
    assign wr_stb_lo = w_fall[IDX_WE_LO];
    assign wr_stb_hi = w_fall[IDX_WE_HI];
    assign bus_err   = (r_state == TOUT);

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_sync.sv
// ============================================================================
// Module : tb_cpu_bus_sync
// Brief  : Self-checking bench for cpu_bus_sync with a sample-window model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_sync;

    localparam int S = 2;
    localparam int F = 2;
    localparam int D = S + F;
    localparam int T = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] bus_addr = '0;
    logic [15:0] bus_data = '0;
    logic        bus_as_n = 1'b1, bus_oe_n = 1'b1, bus_ce_lo_n = 1'b1;
    logic        bus_ce_hi_n = 1'b1, bus_we_lo_n = 1'b1, bus_we_hi_n = 1'b1;
    logic [23:0] addr_q;
    logic [15:0] data_q;
    logic        as_q, oe_q, ce_lo_q, ce_hi_q, we_lo_q, we_hi_q;
    logic        rd_stb, wr_stb_lo, wr_stb_hi, bus_err, proto_err;
    logic [5:0]  q_vec;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    cpu_bus_sync #(.SYNC_STAGES(S), .FILT_LEN(F), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_as_n(bus_as_n), .bus_oe_n(bus_oe_n), .bus_ce_lo_n(bus_ce_lo_n),
        .bus_ce_hi_n(bus_ce_hi_n), .bus_we_lo_n(bus_we_lo_n), .bus_we_hi_n(bus_we_hi_n),
        .addr_q(addr_q), .data_q(data_q), .as_q(as_q), .oe_q(oe_q),
        .ce_lo_q(ce_lo_q), .ce_hi_q(ce_hi_q), .we_lo_q(we_lo_q), .we_hi_q(we_hi_q),
        .rd_stb(rd_stb), .wr_stb_lo(wr_stb_lo), .wr_stb_hi(wr_stb_hi),
        .bus_err(bus_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    assign q_vec = {we_hi_q, we_lo_q, ce_hi_q, ce_lo_q, oe_q, as_q};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_raw(input logic [5:0] r);
        {bus_we_hi_n, bus_we_lo_n, bus_ce_hi_n, bus_ce_lo_n, bus_oe_n, bus_as_n} = r;
    endtask

    // Reference model: a filtered strobe flips when the last F synchronised
    // samples (raw samples S..S+F-1 edges old) all disagree with it.
    logic [D-1:0] m_hist [6];
    logic [23:0]  m_ahist [D];
    logic [15:0]  m_dhist [D];
    logic [5:0]   m_q;
    logic [23:0]  m_addr;
    logic [15:0]  m_data;
    logic         m_rd, m_wrlo, m_wrhi, m_proto, m_err;
    int           m_lowrun;

    initial begin : model
        logic [5:0] raw, old_q, fall;
        logic       flip;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int s = 0; s < 6; s++) m_hist[s] = '1;
                for (int k = 0; k < D; k++) begin
                    m_ahist[k] = '0;
                    m_dhist[k] = '0;
                end
                m_q = '1; m_addr = '0; m_data = '0; m_lowrun = 0;
                {m_rd, m_wrlo, m_wrhi, m_proto, m_err} = '0;
            end else begin
                raw   = {bus_we_hi_n, bus_we_lo_n, bus_ce_hi_n, bus_ce_lo_n, bus_oe_n, bus_as_n};
                old_q = m_q;
                for (int s = 0; s < 6; s++) begin
                    m_hist[s] = {m_hist[s][D-2:0], raw[s]};
                    flip = 1'b1;
                    for (int k = S; k < D; k++) if (m_hist[s][k] == old_q[s]) flip = 1'b0;
                    if (flip) m_q[s] = ~old_q[s];
                end
                for (int k = D - 1; k > 0; k--) begin
                    m_ahist[k] = m_ahist[k-1];
                    m_dhist[k] = m_dhist[k-1];
                end
                m_ahist[0] = bus_addr;
                m_dhist[0] = bus_data;
                if (old_q[0]) m_addr = m_ahist[D-1];
                if (old_q[4] && old_q[5]) m_data = m_dhist[D-1];
                fall    = old_q & ~m_q;
                m_rd    = fall[1] & m_q[4] & m_q[5];
                m_proto = fall[1] & ~(m_q[4] & m_q[5]);
                m_wrlo  = fall[4];
                m_wrhi  = fall[5];
                m_err   = (m_lowrun >= T);
                m_lowrun = m_q[0] ? 0 : ((m_lowrun < 1000) ? m_lowrun + 1 : m_lowrun);
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("strobes", 32'(q_vec), 32'(m_q));
                check("pulses", 32'({rd_stb, wr_stb_lo, wr_stb_hi, proto_err, bus_err}),
                      32'({m_rd, m_wrlo, m_wrhi, m_proto, m_err}));
                check("addr_q", 32'(addr_q), 32'(m_addr));
                check("data_q", 32'(data_q), 32'(m_data));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [5:0]  raw;
        logic [23:0] addr;
        logic [15:0] data;
        logic [5:0]  exp_q;
        logic [23:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin : stim
        int n, n2, n3, n4, lat;
        int fall_at, err_at, rise_at, clr_at;
        logic [15:0] dpulse;
        logic [5:0]  r;

        vecs[0] = '{6'h3F, 24'h000100, 16'h0001, 6'h3F, 24'h000100, 16'h0001};
        vecs[1] = '{6'h3E, 24'h000100, 16'h0001, 6'h3E, 24'h000100, 16'h0001};
        vecs[2] = '{6'h3E, 24'h0ABCDE, 16'h0002, 6'h3E, 24'h000100, 16'h0002};
        vecs[3] = '{6'h0E, 24'h0ABCDE, 16'h0003, 6'h0E, 24'h000100, 16'h0003};
        vecs[4] = '{6'h0E, 24'h0ABCDE, 16'h0004, 6'h0E, 24'h000100, 16'h0003};
        vecs[5] = '{6'h1E, 24'h0ABCDE, 16'h0005, 6'h1E, 24'h000100, 16'h0003};
        vecs[6] = '{6'h3F, 24'h3FFFFF, 16'h0006, 6'h3F, 24'h3FFFFF, 16'h0006};
        vecs[7] = '{6'h31, 24'h123456, 16'h0007, 6'h31, 24'h123456, 16'h0007};
        vecs[8] = '{6'h2F, 24'h123456, 16'h0008, 6'h2F, 24'h123456, 16'h0008};
        vecs[9] = '{6'h3F, 24'hFFFFFF, 16'hFFFF, 6'h3F, 24'hFFFFFF, 16'hFFFF};

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk_en = 1;

        // Reset asserted in the middle of a read access
        bus_addr = 24'h123456; bus_as_n = 1'b0; bus_oe_n = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_strobes", 32'(q_vec), 32'h3F);
        check("rst_pulses", 32'({rd_stb, wr_stb_lo, wr_stb_hi, proto_err, bus_err}), 32'h0);
        check("rst_addr", 32'(addr_q), 32'h0);
        set_raw(6'h3F);
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            edge_wait();
            n += int'(rd_stb) + int'(wr_stb_lo) + int'(wr_stb_hi) + int'(proto_err);
        end
        check("idle_no_pulses", 32'(n), 32'd0);

        // Table of steady bus states
        for (int v = 0; v < 10; v++) begin
            set_raw(vecs[v].raw);
            bus_addr = vecs[v].addr;
            bus_data = vecs[v].data;
            repeat (8) tick();
            check($sformatf("vec%0d_q", v), 32'(q_vec), 32'(vecs[v].exp_q));
            check($sformatf("vec%0d_addr", v), 32'(addr_q), 32'(vecs[v].exp_addr));
            check($sformatf("vec%0d_data", v), 32'(data_q), 32'(vecs[v].exp_data));
        end

        // Read cycle: rd_stb once, four cycles after the raw oe_n fall
        bus_addr = 24'h200000; bus_as_n = 1'b0;
        repeat (3) tick();
        bus_oe_n = 1'b0;
        n = 0; lat = -1;
        for (int i = 1; i <= 12; i++) begin
            edge_wait();
            if (rd_stb) begin
                n++;
                if (lat < 0) lat = i;
            end
            if (i == 6) bus_addr = 24'h0F0F0F;
        end
        check("read_count", 32'(n), 32'd1);
        check("read_latency", 32'(lat), 32'd4);
        check("read_addr_held", 32'(addr_q), 32'h200000);
        set_raw(6'h3F);
        repeat (8) tick();

        // Word write with a data change while the write strobes are low
        bus_data = 16'hA55A; bus_we_lo_n = 1'b0; bus_we_hi_n = 1'b0;
        n = 0; n2 = 0; n3 = 0; dpulse = '0;
        for (int i = 1; i <= 12; i++) begin
            edge_wait();
            if (wr_stb_lo) n++;
            if (wr_stb_hi) n2++;
            if (wr_stb_lo && wr_stb_hi) begin
                n3++;
                dpulse = data_q;
            end
            if (i == 5) bus_data = 16'h1111;
        end
        check("wr_lo_count", 32'(n), 32'd1);
        check("wr_hi_count", 32'(n2), 32'd1);
        check("wr_same_cycle", 32'(n3), 32'd1);
        check("wr_data_at_pulse", 32'(dpulse), 32'hA55A);
        check("wr_data_frozen", 32'(data_q), 32'hA55A);
        set_raw(6'h3F);
        repeat (8) tick();

        // One-cycle glitch on we_lo_n must be filtered out
        bus_we_lo_n = 1'b0;
        tick();
        bus_we_lo_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            edge_wait();
            if (wr_stb_lo || !we_lo_q) n++;
        end
        check("glitch_rejected", 32'(n), 32'd0);

        // Timeout: as_n held low 300 cycles
        bus_as_n = 1'b0;
        fall_at = -1; err_at = -1;
        for (int i = 1; i <= 300; i++) begin
            edge_wait();
            if (!as_q && fall_at < 0) fall_at = i;
            if (bus_err && err_at < 0) err_at = i;
        end
        check("tout_delay", 32'(err_at - fall_at), 32'd255);
        check("tout_held", 32'(bus_err), 32'd1);
        bus_as_n = 1'b1;
        rise_at = -1; clr_at = -1;
        for (int i = 1; i <= 10; i++) begin
            edge_wait();
            if (as_q && rise_at < 0) rise_at = i;
            if (!bus_err && clr_at < 0) clr_at = i;
        end
        check("tout_clear", 32'(clr_at - rise_at), 32'd1);
        repeat (4) tick();

        // Conflict: oe_n and we_hi_n fall together
        bus_oe_n = 1'b0; bus_we_hi_n = 1'b0;
        n = 0; n2 = 0; n3 = 0; n4 = 0;
        for (int i = 0; i < 10; i++) begin
            edge_wait();
            if (wr_stb_hi) n++;
            if (rd_stb) n2++;
            if (proto_err) n3++;
            if (proto_err && wr_stb_hi) n4++;
        end
        check("conf_wr_hi", 32'(n), 32'd1);
        check("conf_rd", 32'(n2), 32'd0);
        check("conf_proto", 32'(n3), 32'd1);
        check("conf_same_cycle", 32'(n4), 32'd1);
        set_raw(6'h3F);
        repeat (8) tick();

        // Random bus activity checked by the model every cycle
        r = 6'h3F;
        for (int c = 0; c < 3000; c++) begin
            int p;
            p = ((c / 200) % 2 == 0) ? 3 : 12;
            for (int s = 0; s < 6; s++) begin
                if ($urandom_range(0, p - 1) == 0) r[s] = ~r[s];
            end
            set_raw(r);
            if ($urandom_range(0, 3) == 0) bus_addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) bus_data = 16'($urandom);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            tick();
        end
        set_raw(6'h3F);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
